ifb_fetch_buffer: RTL and testbench
===================================

// Module: ifb_fetch_buffer
// PURPOSE
//  Instruction fetch buffer on the far side of the IFU PC handshake. Accepts PCs from
//  the IFU and issues them as in-order instruction-memory reads. Pairs each returned
//  word with its PC in a DEPTH-entry queue and presents {pc, inst} to the IDU via
//  valid/ready. On an EXU redirect it discards all queued and in-flight fetches.
// PARAMETERS
//  ADDR_WIDTH  32  PC / memory address width
//  INST_WIDTH  32  instruction word width
//  DEPTH       4   queue entries = max allocated fetches; power of 2, >= 2
// PORTS
//  i_sys_clk        in   1           clock, all logic on rising edge
//  i_sys_rst        in   1           synchronous active-high reset
//  i_ifu_valid      in   1           IFU presents a PC
//  o_ifu_ready      out  1           PC accepted this cycle when both high
//  i_ifu_pc         in   ADDR_WIDTH  PC to fetch
//  i_exu_jmp_en     in   1           redirect: flush queue and in-flight fetches
//  o_mem_req_valid  out  1           read request to instruction memory
//  i_mem_req_ready  in   1           memory accepts the request
//  o_mem_req_addr   out  ADDR_WIDTH  equals i_ifu_pc
//  i_mem_rsp_valid  in   1           read data returned, in request order, always accepted
//  i_mem_rsp_data   in   INST_WIDTH  instruction word
//  o_idu_valid      out  1           head entry complete
//  i_idu_ready      in   1           IDU consumes head when both high
//  o_idu_pc         out  ADDR_WIDTH  head PC, 0 when !o_idu_valid
//  o_idu_inst       out  INST_WIDTH  head instruction, 0 when !o_idu_valid
// BEHAVIOUR
//  - Reset: pointers, occupancy, inflight and drop counters = 0; all outputs 0.
//    Reset mid-operation abandons all state; later responses are illegal until a new request.
//  - Credit: can_issue = (occupancy < DEPTH) && (inflight < DEPTH) && !i_exu_jmp_en.
//  - o_mem_req_valid = i_ifu_valid && can_issue.
//    o_ifu_ready = i_mem_req_ready && can_issue. Combinational pass-through, zero latency.
//  - Issue (ifu handshake): allocate the entry at wr_ptr, store pc, clear done,
//    wr_ptr++, occupancy++, inflight++.
//  - Response: if drop_cnt > 0, discard and drop_cnt--. Otherwise write inst into the
//    entry at fill_ptr, set done, fill_ptr++. inflight-- in both cases.
//  - o_idu_valid = (occupancy > 0) && done[rd_ptr]; registered state only, no combinational
//    path from i_mem_rsp_* or i_exu_jmp_en. Min latency: response in cycle N -> o_idu_valid in N+1.
//  - Pop (idu handshake): rd_ptr++, occupancy--. Issue and pop in the same cycle leave occupancy unchanged.
//  - Flush (i_exu_jmp_en=1): at the next edge, occupancy=0 and wr/fill/rd_ptr=0.
//    drop_cnt <= drop_cnt + (entries allocated but not done) - (this cycle's response,
//    if it was not already a drop). No issue in the flush cycle.
//    A pop handshake in the flush cycle counts as consumed; the IDU owns squashing it.
//    The cycle after a flush may issue, including while drops are pending.
//  - Pointers wrap modulo DEPTH. Counters are clog2(DEPTH)+1 bits and never exceed DEPTH.
//  - i_mem_rsp_valid with inflight == 0 is illegal and is asserted against. State is unchanged.
// STRUCTURE
//  - ifb_pkg: ifb_entry_t {pc, inst, done}, PTR_W = $clog2(DEPTH), CNT_W = PTR_W+1.
//  - One sub-module ifb_entry_array: DEPTH x ifb_entry_t register file with three ports
//    (alloc write, fill write, head read) and a flash-clear of done bits.
//  - Credit, pointer and drop control stay in the top level.
// TESTING
//  1 Reset: hold i_sys_rst 2 cycles -> all outputs 0. o_ifu_ready = i_mem_req_ready once released.
//  2 Stream: PCs 0x8000_0000,+4,+8, mem 1-cycle latency, idu_ready=1 -> IDU sees the three pairs
//    in order, first o_idu_valid 2 cycles after the first issue.
//  3 Full: idu_ready=0, 5 PCs offered, DEPTH=4 -> 4 accepted, o_ifu_ready=0 after the 4th.
//    One pop -> the 5th is accepted next cycle.
//  4 Flush in flight: issue 3, return 1, pulse jmp -> 2 later responses are dropped. A new PC
//    0x8000_0100 issued next cycle appears at the IDU with the 3rd response's data.
//  5 Flush coincident: jmp in the same cycle as a response and a pop -> response dropped,
//    occupancy 0, drop_cnt matches the remaining in-flight count, no output next cycle.
//  6 Backpressure: i_mem_req_ready=0 for 3 cycles -> o_ifu_ready=0, no allocation,
//    o_mem_req_valid held with a stable address.

Source files
------------

// File: rtl/ifb_pkg.sv
// rtl/ifb_pkg.sv - shared types and widths for the instruction fetch buffer
package ifb_pkg;

    localparam int IFB_ADDR_W = 32;
    localparam int IFB_INST_W = 32;
    localparam int IFB_DEPTH  = 4;
    localparam int PTR_W      = $clog2(IFB_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    typedef struct packed {
        logic [IFB_ADDR_W-1:0] pc;
        logic [IFB_INST_W-1:0] inst;
        logic                  done;
    } ifb_entry_t;

endpackage

// File: rtl/ifb_fetch_buffer_if.sv
// rtl/ifb_fetch_buffer_if.sv - IFU, instruction memory and IDU handshake bundle
interface ifb_fetch_buffer_if
    import ifb_pkg::*;
#(
    parameter int ADDR_WIDTH = IFB_ADDR_W,
    parameter int INST_WIDTH = IFB_INST_W
);
    logic                  i_ifu_valid;
    logic                  o_ifu_ready;
    logic [ADDR_WIDTH-1:0] i_ifu_pc;
    logic                  i_exu_jmp_en;
    logic                  o_mem_req_valid;
    logic                  i_mem_req_ready;
    logic [ADDR_WIDTH-1:0] o_mem_req_addr;
    logic                  i_mem_rsp_valid;
    logic [INST_WIDTH-1:0] i_mem_rsp_data;
    logic                  o_idu_valid;
    logic                  i_idu_ready;
    logic [ADDR_WIDTH-1:0] o_idu_pc;
    logic [INST_WIDTH-1:0] o_idu_inst;

    modport slave (
        input  i_ifu_valid, i_ifu_pc, i_exu_jmp_en, i_mem_req_ready,
               i_mem_rsp_valid, i_mem_rsp_data, i_idu_ready,
        output o_ifu_ready, o_mem_req_valid, o_mem_req_addr,
               o_idu_valid, o_idu_pc, o_idu_inst
    );

    modport master (
        output i_ifu_valid, i_ifu_pc, i_exu_jmp_en, i_mem_req_ready,
               i_mem_rsp_valid, i_mem_rsp_data, i_idu_ready,
        input  o_ifu_ready, o_mem_req_valid, o_mem_req_addr,
               o_idu_valid, o_idu_pc, o_idu_inst
    );
endinterface

// File: rtl/ifb_entry_array.sv
// rtl/ifb_entry_array.sv - fetch queue storage: alloc write, fill write, head read
module ifb_entry_array
    import ifb_pkg::*;
#(
    parameter int DEPTH = IFB_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  alloc_en,
    input  logic [IDX_W-1:0]      alloc_idx,
    input  logic [IFB_ADDR_W-1:0] alloc_pc,
    input  logic                  fill_en,
    input  logic [IDX_W-1:0]      fill_idx,
    input  logic [IFB_INST_W-1:0] fill_inst,
    input  logic                  clear_done,
    input  logic [IDX_W-1:0]      rd_idx,
    output ifb_entry_t            rd_entry
);

    ifb_entry_t mem [DEPTH];

    // Only done needs a reset value; pc/inst are never observed without it.
    always_ff @(posedge i_sys_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_sys_rst || clear_done) begin
                mem[i].done <= 1'b0;
            end else begin
                if (alloc_en && alloc_idx == IDX_W'(i)) begin
                    mem[i].pc   <= alloc_pc;
                    mem[i].done <= 1'b0;
                end
                if (fill_en && fill_idx == IDX_W'(i)) begin
                    mem[i].inst <= fill_inst;
                    mem[i].done <= 1'b1;
                end
            end
        end
    end

    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/ifb_fetch_buffer.sv
// rtl/ifb_fetch_buffer.sv - in-order instruction fetch queue between IFU, imem and IDU
module ifb_fetch_buffer
    import ifb_pkg::*;
#(
    parameter int ADDR_WIDTH = IFB_ADDR_W,
    parameter int INST_WIDTH = IFB_INST_W,
    parameter int DEPTH      = IFB_DEPTH
) (
    input  logic               i_sys_clk,
    input  logic               i_sys_rst,
    ifb_fetch_buffer_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CW    = IDX_W + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [IDX_W-1:0] wr_ptr, fill_ptr, rd_ptr;
    logic [CW-1:0]    occ_cnt, inflight_cnt, drop_cnt;
    logic             can_issue, issue, rsp, rsp_drop, rsp_fill, pop, flush, idu_valid;
    ifb_entry_t       head;

    assign flush     = bus.i_exu_jmp_en;
    assign can_issue = !i_sys_rst && (occ_cnt < FULL) && (inflight_cnt < FULL) && !flush;

    assign bus.o_mem_req_valid = bus.i_ifu_valid && can_issue;
    assign bus.o_ifu_ready     = bus.i_mem_req_ready && can_issue;
    assign bus.o_mem_req_addr  = bus.i_ifu_pc;

    assign issue    = bus.i_ifu_valid && bus.i_mem_req_ready && can_issue;
    assign rsp      = bus.i_mem_rsp_valid && (inflight_cnt != '0);
    assign rsp_drop = rsp && (drop_cnt != '0);
    assign rsp_fill = rsp && (drop_cnt == '0);

    assign idu_valid       = (occ_cnt != '0) && head.done;
    assign pop             = idu_valid && bus.i_idu_ready;
    assign bus.o_idu_valid = idu_valid;
    assign bus.o_idu_pc    = idu_valid ? ADDR_WIDTH'(head.pc)   : '0;
    assign bus.o_idu_inst  = idu_valid ? INST_WIDTH'(head.inst) : '0;

    ifb_entry_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_entries (
        .i_sys_clk  (i_sys_clk),
        .i_sys_rst  (i_sys_rst),
        .alloc_en   (issue),
        .alloc_idx  (wr_ptr),
        .alloc_pc   (IFB_ADDR_W'(bus.i_ifu_pc)),
        .fill_en    (rsp_fill && !flush),
        .fill_idx   (fill_ptr),
        .fill_inst  (IFB_INST_W'(bus.i_mem_rsp_data)),
        .clear_done (flush),
        .rd_idx     (rd_ptr),
        .rd_entry   (head)
    );

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            wr_ptr       <= '0;
            fill_ptr     <= '0;
            rd_ptr       <= '0;
            occ_cnt      <= '0;
            inflight_cnt <= '0;
            drop_cnt     <= '0;
        end else if (flush) begin
            // Every surviving in-flight read is now stale, so the drop count
            // becomes whatever is still in flight after this cycle's response.
            wr_ptr       <= '0;
            fill_ptr     <= '0;
            rd_ptr       <= '0;
            occ_cnt      <= '0;
            inflight_cnt <= inflight_cnt - CW'(rsp);
            drop_cnt     <= inflight_cnt - CW'(rsp);
        end else begin
            wr_ptr       <= wr_ptr + IDX_W'(issue);
            fill_ptr     <= fill_ptr + IDX_W'(rsp_fill);
            rd_ptr       <= rd_ptr + IDX_W'(pop);
            occ_cnt      <= occ_cnt + CW'(issue) - CW'(pop);
            inflight_cnt <= inflight_cnt + CW'(issue) - CW'(rsp);
            drop_cnt     <= drop_cnt - CW'(rsp_drop);
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst && bus.i_mem_rsp_valid) begin
            assert (inflight_cnt != '0);
        end
    end

endmodule

// File: tb/tb_ifb_fetch_buffer.sv
// tb/tb_ifb_fetch_buffer.sv - directed self-checking bench for ifb_fetch_buffer
module tb_ifb_fetch_buffer;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    ifb_fetch_buffer_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

    ifb_fetch_buffer #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(4)) dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ifu_v, input logic [31:0] pc, input logic req_rdy,
                         input logic rsp_v, input logic [31:0] rsp_d, input logic jmp,
                         input logic idu_rdy);
        bus.i_ifu_valid     = ifu_v;
        bus.i_ifu_pc        = pc;
        bus.i_mem_req_ready = req_rdy;
        bus.i_mem_rsp_valid = rsp_v;
        bus.i_mem_rsp_data  = rsp_d;
        bus.i_exu_jmp_en    = jmp;
        bus.i_idu_ready     = idu_rdy;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idu(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst);
        chk({tag, ".valid"}, 64'(bus.o_idu_valid), 64'(v));
        chk({tag, ".pc"},    64'(bus.o_idu_pc),    64'(pc));
        chk({tag, ".inst"},  64'(bus.o_idu_inst),  64'(inst));
    endtask

    initial begin
        // 1: reset
        rst = 1'b1;
        drive(1, 32'h0, 1, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst.ifu_ready", 64'(bus.o_ifu_ready), 64'd0);
        chk("rst.mem_req_valid", 64'(bus.o_mem_req_valid), 64'd0);
        chk_idu("rst", 0, 0, 0);
        chk("rst.occ", 64'(dut.occ_cnt), 64'd0);
        rst = 1'b0;
        drive(0, 32'h0, 1, 0, 0, 0, 0);
        chk("rel.ifu_ready1", 64'(bus.o_ifu_ready), 64'd1);
        drive(0, 32'h0, 0, 0, 0, 0, 0);
        chk("rel.ifu_ready0", 64'(bus.o_ifu_ready), 64'd0);
        tick();

        // 2: stream with 1-cycle memory latency
        drive(1, 32'h8000_0000, 1, 0, 0, 0, 1);
        chk("str.req_valid", 64'(bus.o_mem_req_valid), 64'd1);
        chk("str.req_addr", 64'(bus.o_mem_req_addr), 64'h8000_0000);
        chk("str.ifu_ready", 64'(bus.o_ifu_ready), 64'd1);
        tick();
        drive(1, 32'h8000_0004, 1, 1, 32'hA000_0000, 0, 1);
        chk("str.c1.valid", 64'(bus.o_idu_valid), 64'd0);
        tick();
        drive(1, 32'h8000_0008, 1, 1, 32'hA000_0001, 0, 1);
        chk_idu("str.o0", 1, 32'h8000_0000, 32'hA000_0000);
        tick();
        drive(0, 32'h0, 1, 1, 32'hA000_0002, 0, 1);
        chk_idu("str.o1", 1, 32'h8000_0004, 32'hA000_0001);
        tick();
        drive(0, 32'h0, 1, 0, 0, 0, 1);
        chk_idu("str.o2", 1, 32'h8000_0008, 32'hA000_0002);
        tick();
        chk_idu("str.end", 0, 0, 0);
        chk("str.occ", 64'(dut.occ_cnt), 64'd0);

        // 3: fill the queue, one pop frees a slot, then drain across the wrap
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h1000 + 32'(4 * i), 1, 0, 0, 0, 0);
            chk($sformatf("full.acc%0d", i), 64'(bus.o_ifu_ready), 64'd1);
            tick();
        end
        drive(1, 32'h1010, 1, 1, 32'hD000_0000, 0, 0);
        chk("full.rej", 64'(bus.o_ifu_ready), 64'd0);
        tick();
        drive(1, 32'h1010, 1, 0, 0, 0, 1);
        chk("full.rej2", 64'(bus.o_ifu_ready), 64'd0);
        chk_idu("full.h0", 1, 32'h1000, 32'hD000_0000);
        tick();
        drive(1, 32'h1010, 1, 0, 0, 0, 0);
        chk("full.acc5", 64'(bus.o_ifu_ready), 64'd1);
        tick();
        drive(0, 0, 1, 1, 32'hD000_0001, 0, 1);
        chk("full.nodone", 64'(bus.o_idu_valid), 64'd0);
        tick();
        for (int i = 1; i < 5; i++) begin
            if (i < 4) drive(0, 0, 1, 1, 32'hD000_0000 + 32'(i + 1), 0, 1);
            else       drive(0, 0, 1, 0, 0, 0, 1);
            chk_idu($sformatf("full.h%0d", i), 1, 32'h1000 + 32'(4 * i), 32'hD000_0000 + 32'(i));
            tick();
        end
        drive(0, 0, 1, 0, 0, 0, 0);
        chk_idu("full.end", 0, 0, 0);
        chk("full.inflight", 64'(dut.inflight_cnt), 64'd0);

        // 4: flush with two reads still in flight
        drive(1, 32'h2000, 1, 0, 0, 0, 0);
        tick();
        drive(1, 32'h2004, 1, 0, 0, 0, 0);
        tick();
        drive(1, 32'h2008, 1, 1, 32'hB000_0000, 0, 0);
        tick();
        drive(1, 32'h8000_0100, 1, 0, 0, 1, 0);
        chk("fl.req_valid", 64'(bus.o_mem_req_valid), 64'd0);
        chk("fl.ifu_ready", 64'(bus.o_ifu_ready), 64'd0);
        tick();
        drive(1, 32'h8000_0100, 1, 1, 32'hB000_0001, 0, 0);
        chk("fl.drop2", 64'(dut.drop_cnt), 64'd2);
        chk("fl.ifu_ready2", 64'(bus.o_ifu_ready), 64'd1);
        chk_idu("fl.c5", 0, 0, 0);
        tick();
        drive(0, 0, 1, 1, 32'hB000_0002, 0, 0);
        chk("fl.drop1", 64'(dut.drop_cnt), 64'd1);
        chk("fl.c6.valid", 64'(bus.o_idu_valid), 64'd0);
        tick();
        drive(0, 0, 1, 1, 32'hB000_0003, 0, 0);
        chk("fl.c7.valid", 64'(bus.o_idu_valid), 64'd0);
        tick();
        drive(0, 0, 1, 0, 0, 0, 1);
        chk_idu("fl.new", 1, 32'h8000_0100, 32'hB000_0003);
        tick();
        drive(0, 0, 1, 0, 0, 0, 0);
        chk_idu("fl.end", 0, 0, 0);
        chk("fl.drop0", 64'(dut.drop_cnt), 64'd0);

        // 5: flush coincident with a response and a pop
        drive(1, 32'h4000, 1, 0, 0, 0, 0);
        tick();
        drive(1, 32'h4004, 1, 1, 32'hC000_0000, 0, 0);
        tick();
        drive(1, 32'h4008, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 1, 32'hC000_0001, 1, 1);
        chk_idu("co.pop", 1, 32'h4000, 32'hC000_0000);
        tick();
        drive(0, 0, 1, 1, 32'hC000_0002, 0, 1);
        chk_idu("co.after", 0, 0, 0);
        chk("co.occ", 64'(dut.occ_cnt), 64'd0);
        chk("co.drop", 64'(dut.drop_cnt), 64'd1);
        chk("co.inflight", 64'(dut.inflight_cnt), 64'd1);
        tick();
        drive(0, 0, 1, 0, 0, 0, 1);
        chk("co.drop0", 64'(dut.drop_cnt), 64'd0);
        chk("co.inflight0", 64'(dut.inflight_cnt), 64'd0);
        chk("co.valid", 64'(bus.o_idu_valid), 64'd0);

        // 6: memory backpressure
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h3000, 0, 0, 0, 0, 0);
            chk($sformatf("bp.ifu_ready%0d", i), 64'(bus.o_ifu_ready), 64'd0);
            chk($sformatf("bp.req_valid%0d", i), 64'(bus.o_mem_req_valid), 64'd1);
            chk($sformatf("bp.addr%0d", i), 64'(bus.o_mem_req_addr), 64'h3000);
            chk($sformatf("bp.occ%0d", i), 64'(dut.occ_cnt), 64'd0);
            tick();
        end
        drive(1, 32'h3000, 1, 0, 0, 0, 0);
        chk("bp.release", 64'(bus.o_ifu_ready), 64'd1);
        tick();
        drive(0, 0, 1, 1, 32'hE000_0000, 0, 1);
        chk("bp.occ1", 64'(dut.occ_cnt), 64'd1);
        tick();
        drive(0, 0, 1, 0, 0, 0, 1);
        chk_idu("bp.out", 1, 32'h3000, 32'hE000_0000);
        tick();
        drive(0, 0, 1, 0, 0, 0, 0);
        chk_idu("bp.end", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
